bf_code_loader: RTL and testbench

Upstream feeder for brainfuckCore's code memory. It accepts a byte stream over a valid/ready handshake, for example from a UART receiver. It keeps only the eight Brainfuck opcodes and writes them sequentially into the code RAM, which brainfuckCore reads through addr_code/code_out. It checks bracket balance, appends a 0x00 end-of-program marker, and only then releases the core via core_run.

---
 rtl/bf_pkg.sv | 36 +++
 rtl/bf_code_loader_if.sv | 34 +++
 rtl/bf_bracket_checker.sv | 39 +++
 rtl/bf_code_loader.sv | 140 ++++++++++++++
 tb/tb_bf_code_loader.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/bf_pkg.sv
// Shared definitions for the Brainfuck code loader: opcode bytes, FSM and error encodings.
package bf_pkg;

  localparam logic [7:0] OP_INC   = 8'h2B;
  localparam logic [7:0] OP_DEC   = 8'h2D;
  localparam logic [7:0] OP_LEFT  = 8'h3C;
  localparam logic [7:0] OP_RIGHT = 8'h3E;
  localparam logic [7:0] OP_OPEN  = 8'h5B;
  localparam logic [7:0] OP_CLOSE = 8'h5D;
  localparam logic [7:0] OP_OUT   = 8'h2E;
  localparam logic [7:0] OP_IN    = 8'h2C;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_MARK = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } loader_state_e;

  typedef enum logic [1:0] {
    ERR_NONE            = 2'd0,
    ERR_UNMATCHED_CLOSE = 2'd1,
    ERR_UNMATCHED_OPEN  = 2'd2,
    ERR_OVERFLOW        = 2'd3
  } err_code_e;

  function automatic logic is_opcode(input logic [7:0] b);
    case (b)
      OP_INC, OP_DEC, OP_LEFT, OP_RIGHT,
      OP_OPEN, OP_CLOSE, OP_OUT, OP_IN: is_opcode = 1'b1;
      default:                          is_opcode = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/bf_code_loader_if.sv
// Byte-stream, code-RAM write and status bundle of the code loader.
interface bf_code_loader_if #(
  parameter int ADDR_WIDTH = 9
);
  import bf_pkg::*;

  logic                  start;
  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [7:0]            mem_data;
  logic                  mem_we;
  logic                  core_run;
  logic                  done;
  logic                  error;
  logic [1:0]            err_code;
  logic [ADDR_WIDTH-1:0] prog_len;

  // Driver side: the byte source and whoever observes the load status.
  modport master (
    output start, in_data, in_valid,
    input  in_ready, mem_addr, mem_data, mem_we,
    input  core_run, done, error, err_code, prog_len
  );

  // Loader side.
  modport slave (
    input  start, in_data, in_valid,
    output in_ready, mem_addr, mem_data, mem_we,
    output core_run, done, error, err_code, prog_len
  );

endinterface

// File: rtl/bf_bracket_checker.sv
// Tracks '[' / ']' nesting depth and flags unmatched brackets combinationally.
module bf_bracket_checker
  import bf_pkg::*;
#(
  parameter int ADDR_WIDTH = 9
) (
  input  logic clk,
  input  logic reset,
  input  logic i_open,
  input  logic i_close,
  input  logic i_clear,
  input  logic i_check_end,
  output logic o_err_unmatched_close,
  output logic o_err_unmatched_open
);

  localparam logic [ADDR_WIDTH-1:0] DEPTH_ZERO = '0;
  localparam logic [ADDR_WIDTH-1:0] DEPTH_ONE  = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] r_depth;
  logic                  w_depth_zero;

  assign w_depth_zero          = (r_depth == DEPTH_ZERO);
  assign o_err_unmatched_close = i_close && w_depth_zero;
  assign o_err_unmatched_open  = i_check_end && !w_depth_zero;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_depth <= DEPTH_ZERO;
    end else if (i_clear) begin
      r_depth <= DEPTH_ZERO;
    end else if (i_open) begin
      r_depth <= r_depth + DEPTH_ONE;
    end else if (i_close && !w_depth_zero) begin
      r_depth <= r_depth - DEPTH_ONE;
    end
  end

endmodule

// File: rtl/bf_code_loader.sv
// Filters a byte stream down to Brainfuck opcodes, writes them into code RAM,
// appends a 0x00 marker and releases the core only after a clean load.
module bf_code_loader
  import bf_pkg::*;
#(
  parameter int         ADDR_WIDTH = 9,
  parameter logic [7:0] TERM_CHAR  = 8'h21
) (
  input  logic             clk,
  input  logic             reset,
  bf_code_loader_if.slave  bus
);

  localparam logic [ADDR_WIDTH-1:0] LEN_ZERO = '0;
  localparam logic [ADDR_WIDTH-1:0] LEN_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] LEN_MAX  = '1;

  loader_state_e         r_state;
  logic                  r_in_ready;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [7:0]            r_mem_data;
  logic                  r_mem_we;
  logic                  r_core_run;
  logic                  r_done;
  logic                  r_error;
  err_code_e             r_err_code;
  logic [ADDR_WIDTH-1:0] r_prog_len;

  logic w_accept;
  logic w_is_op;
  logic w_is_term;
  logic w_full;
  logic w_restart;
  logic w_err_close;
  logic w_err_open;

  assign w_accept  = bus.in_valid && r_in_ready;
  assign w_is_op   = is_opcode(bus.in_data);
  assign w_is_term = (bus.in_data == TERM_CHAR);
  assign w_full    = (r_prog_len == LEN_MAX);
  assign w_restart = bus.start && (r_state != ST_LOAD) && (r_state != ST_MARK);

  // A full buffer turns any opcode into an overflow, so the depth must not move.
  bf_bracket_checker #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_brackets (
    .clk                   (clk),
    .reset                 (reset),
    .i_open                (w_accept && !w_full && (bus.in_data == OP_OPEN)),
    .i_close               (w_accept && !w_full && (bus.in_data == OP_CLOSE)),
    .i_clear               (w_restart),
    .i_check_end           (w_accept && w_is_term),
    .o_err_unmatched_close (w_err_close),
    .o_err_unmatched_open  (w_err_open)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_in_ready <= 1'b0;
      r_mem_addr <= LEN_ZERO;
      r_mem_data <= 8'h00;
      r_mem_we   <= 1'b0;
      r_core_run <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_err_code <= ERR_NONE;
      r_prog_len <= LEN_ZERO;
    end else begin
      r_mem_we <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (bus.start) begin
            r_state    <= ST_LOAD;
            r_in_ready <= 1'b1;
            r_prog_len <= LEN_ZERO;
            r_core_run <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_err_code <= ERR_NONE;
          end
        end
        ST_LOAD: begin
          if (w_accept && w_is_op) begin
            if (w_full) begin
              r_state    <= ST_ERR;
              r_in_ready <= 1'b0;
              r_error    <= 1'b1;
              r_err_code <= ERR_OVERFLOW;
            end else if (w_err_close) begin
              r_state    <= ST_ERR;
              r_in_ready <= 1'b0;
              r_error    <= 1'b1;
              r_err_code <= ERR_UNMATCHED_CLOSE;
            end else begin
              r_mem_we   <= 1'b1;
              r_mem_addr <= r_prog_len;
              r_mem_data <= bus.in_data;
              r_prog_len <= r_prog_len + LEN_ONE;
            end
          end else if (w_accept && w_is_term) begin
            r_in_ready <= 1'b0;
            if (w_err_open) begin
              r_state    <= ST_ERR;
              r_error    <= 1'b1;
              r_err_code <= ERR_UNMATCHED_OPEN;
            end else begin
              // Marker lands at prog_len and is not counted in it.
              r_state    <= ST_MARK;
              r_mem_we   <= 1'b1;
              r_mem_addr <= r_prog_len;
              r_mem_data <= 8'h00;
            end
          end
        end
        ST_MARK: begin
          r_state    <= ST_DONE;
          r_done     <= 1'b1;
          r_core_run <= 1'b1;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_in_ready <= 1'b0;
          r_core_run <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready = r_in_ready;
  assign bus.mem_addr = r_mem_addr;
  assign bus.mem_data = r_mem_data;
  assign bus.mem_we   = r_mem_we;
  assign bus.core_run = r_core_run;
  assign bus.done     = r_done;
  assign bus.error    = r_error;
  assign bus.err_code = r_err_code;
  assign bus.prog_len = r_prog_len;

endmodule

// File: tb/tb_bf_code_loader.sv
// Directed bench for bf_code_loader: writes are logged on the falling edge and compared to hand-computed tables.
module tb_bf_code_loader;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  logic [8:0] log_addr[$];
  logic [7:0] log_data[$];

  bf_code_loader_if #(.ADDR_WIDTH(9)) bus ();

  bf_code_loader #(
    .ADDR_WIDTH (9),
    .TERM_CHAR  (8'h21)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      log_addr.push_back(bus.mem_addr);
      log_data.push_back(bus.mem_data);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_write(input string tag, input int idx, input logic [8:0] a, input logic [7:0] d);
    chk({tag, "_addr"}, {23'd0, log_addr[idx]}, {23'd0, a});
    chk({tag, "_data"}, {24'd0, log_data[idx]}, {24'd0, d});
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // One byte per cycle; optional idle cycle between bytes with junk on in_data.
  task automatic send_str(input string s, input bit gaps);
    for (int i = 0; i < s.len(); i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = s[i];
      @(negedge clk);
      bus.in_valid = 1'b0;
      if (gaps) begin
        bus.in_data = 8'h2B;
        @(negedge clk);
      end
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
    chk({tag, "_mem_we"},   {31'd0, bus.mem_we},   32'd0);
    chk({tag, "_mem_addr"}, {23'd0, bus.mem_addr}, 32'd0);
    chk({tag, "_mem_data"}, {24'd0, bus.mem_data}, 32'd0);
    chk({tag, "_core_run"}, {31'd0, bus.core_run}, 32'd0);
    chk({tag, "_done"},     {31'd0, bus.done},     32'd0);
    chk({tag, "_error"},    {31'd0, bus.error},    32'd0);
    chk({tag, "_err_code"}, {30'd0, bus.err_code}, 32'd0);
    chk({tag, "_prog_len"}, {23'd0, bus.prog_len}, 32'd0);
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    reset        = 1'b1;
    #1;
    chk_idle_outputs("reset");
    cycles(2);
    reset = 1'b0;
    cycles(1);
    chk("idle_in_ready", {31'd0, bus.in_ready}, 32'd0);

    // Basic load "+[-]!"
    clear_log();
    do_start();
    chk("load_in_ready", {31'd0, bus.in_ready}, 32'd1);
    send_str("+[-]!", 1'b0);
    cycles(2);
    chk("basic_nwrites", log_addr.size(), 32'd5);
    chk_write("basic_w0", 0, 9'd0, 8'h2B);
    chk_write("basic_w1", 1, 9'd1, 8'h5B);
    chk_write("basic_w2", 2, 9'd2, 8'h2D);
    chk_write("basic_w3", 3, 9'd3, 8'h5D);
    chk_write("basic_w4", 4, 9'd4, 8'h00);
    chk("basic_done",     {31'd0, bus.done},     32'd1);
    chk("basic_core_run", {31'd0, bus.core_run}, 32'd1);
    chk("basic_prog_len", {23'd0, bus.prog_len}, 32'd4);
    chk("basic_err_code", {30'd0, bus.err_code}, 32'd0);

    // Comment filtering "a+ b\n-!"
    clear_log();
    do_start();
    chk("restart_done",     {31'd0, bus.done},     32'd0);
    chk("restart_core_run", {31'd0, bus.core_run}, 32'd0);
    send_str("a+ b\n-!", 1'b0);
    cycles(2);
    chk("filt_nwrites", log_addr.size(), 32'd3);
    chk_write("filt_w0", 0, 9'd0, 8'h2B);
    chk_write("filt_w1", 1, 9'd1, 8'h2D);
    chk_write("filt_w2", 2, 9'd2, 8'h00);
    chk("filt_prog_len", {23'd0, bus.prog_len}, 32'd2);
    chk("filt_done",     {31'd0, bus.done},     32'd1);

    // Unmatched close "]": error reported in the cycle after acceptance
    clear_log();
    do_start();
    send_str("]", 1'b0);
    chk("uclose_error",    {31'd0, bus.error},    32'd1);
    chk("uclose_err_code", {30'd0, bus.err_code}, 32'd1);
    chk("uclose_mem_we",   {31'd0, bus.mem_we},   32'd0);
    chk("uclose_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("uclose_core_run", {31'd0, bus.core_run}, 32'd0);
    cycles(1);
    chk("uclose_nwrites", log_addr.size(), 32'd0);

    // Recovery from ERR: "+!"
    clear_log();
    do_start();
    chk("recover_error", {31'd0, bus.error}, 32'd0);
    send_str("+!", 1'b0);
    cycles(2);
    chk("recover_prog_len", {23'd0, bus.prog_len}, 32'd1);
    chk("recover_done",     {31'd0, bus.done},     32'd1);
    chk("recover_err_code", {30'd0, bus.err_code}, 32'd0);
    chk("recover_nwrites",  log_addr.size(), 32'd2);
    chk_write("recover_w1", 1, 9'd1, 8'h00);

    // Unmatched open "[[]!"
    clear_log();
    do_start();
    send_str("[[]!", 1'b0);
    chk("uopen_error",    {31'd0, bus.error},    32'd1);
    chk("uopen_err_code", {30'd0, bus.err_code}, 32'd2);
    cycles(2);
    chk("uopen_nwrites", log_addr.size(), 32'd3);
    chk_write("uopen_w2", 2, 9'd2, 8'h5D);
    chk("uopen_core_run", {31'd0, bus.core_run}, 32'd0);

    // Start with in_valid high is not consumed; empty program gives marker at 0
    clear_log();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h2B;
    do_start();
    send_str("!", 1'b0);
    cycles(2);
    chk("empty_nwrites", log_addr.size(), 32'd1);
    chk_write("empty_w0", 0, 9'd0, 8'h00);
    chk("empty_prog_len", {23'd0, bus.prog_len}, 32'd0);
    chk("empty_done",     {31'd0, bus.done},     32'd1);

    // Overflow: 512 '+' bytes, only 511 written
    clear_log();
    do_start();
    for (int i = 0; i < 512; i++) send_str("+", 1'b0);
    chk("ovf_error",    {31'd0, bus.error},    32'd1);
    chk("ovf_err_code", {30'd0, bus.err_code}, 32'd3);
    cycles(2);
    chk("ovf_nwrites",  log_addr.size(), 32'd511);
    chk_write("ovf_last", 510, 9'd510, 8'h2B);
    chk("ovf_prog_len", {23'd0, bus.prog_len}, 32'd511);

    // Backpressure: gaps between bytes
    clear_log();
    do_start();
    send_str("+>!", 1'b1);
    cycles(2);
    chk("bp_nwrites", log_addr.size(), 32'd3);
    chk_write("bp_w0", 0, 9'd0, 8'h2B);
    chk_write("bp_w1", 1, 9'd1, 8'h3E);
    chk_write("bp_w2", 2, 9'd2, 8'h00);
    chk("bp_prog_len", {23'd0, bus.prog_len}, 32'd2);

    // Asynchronous reset mid-load, between clock edges
    clear_log();
    do_start();
    send_str("++", 1'b0);
    chk("midrst_pre_we",  {31'd0, bus.mem_we},   32'd1);
    chk("midrst_pre_len", {23'd0, bus.prog_len}, 32'd2);
    #2;
    reset = 1'b1;
    #1;
    chk_idle_outputs("midrst");
    cycles(1);
    reset = 1'b0;
    cycles(2);
    chk("postrst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    clear_log();
    do_start();
    send_str("-!", 1'b0);
    cycles(2);
    chk("postrst_prog_len", {23'd0, bus.prog_len}, 32'd1);
    chk("postrst_nwrites",  log_addr.size(), 32'd2);
    chk_write("postrst_w0", 0, 9'd0, 8'h2D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
